// File: rtl/asrv32_vic.sv
// asrv32_vic: memory-mapped interrupt controller holding mtime, mtimecmp and msip.
// Single-cycle bus: strobe in, registered ack and pre-access read data one cycle later.
module asrv32_vic #(
    parameter logic [31:0] BASE_ADDR      = 32'h8000_0000,
    parameter int unsigned MTIME_PRESCALE = 1
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic [31:0] i_addr,
    input  logic [31:0] i_data,
    input  logic [3:0]  i_wr_mask,
    input  logic        i_wr_en,
    input  logic        i_stb,
    output logic        o_ack,
    output logic [31:0] o_data,
    output logic        o_timer_interrupt,
    output logic        o_software_interrupt
);

    localparam int unsigned DW = 32;
    localparam int unsigned TW = 64;
    localparam int unsigned PW = (MTIME_PRESCALE > 1) ? $clog2(MTIME_PRESCALE) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(MTIME_PRESCALE - 1);

    localparam logic [2:0] REG_MTIME_LO = 3'd0;
    localparam logic [2:0] REG_MTIME_HI = 3'd1;
    localparam logic [2:0] REG_CMP_LO   = 3'd2;
    localparam logic [2:0] REG_CMP_HI   = 3'd3;
    localparam logic [2:0] REG_MSIP     = 3'd4;

    logic [PW-1:0] presc_q, presc_d;
    logic [TW-1:0] mtime_q, mtime_d;
    logic [TW-1:0] mtimecmp_q, mtimecmp_d;
    logic          msip_q, msip_d;
    logic          ack_q;
    logic [DW-1:0] rdata_q;
    logic          timer_irq_q;
    logic          sw_irq_q;

    logic          wr_c;
    logic [2:0]    sel_c;
    logic          tick_c;
    logic          mtime_wr_c;
    logic [DW-1:0] rdata_c;

    // Window offset bits above the register index and the base itself are not decoded.
    logic unused_c;
    assign unused_c = ^{i_addr[31:5], i_addr[1:0], BASE_ADDR};

    // Replace only the bytes whose mask bit is set.
    function automatic logic [DW-1:0] merge_bytes(input logic [DW-1:0] old_v,
                                                  input logic [DW-1:0] new_v,
                                                  input logic [3:0]    mask);
        logic [DW-1:0] res;
        res = old_v;
        for (int b = 0; b < 4; b++) begin
            if (mask[b]) begin
                res[8*b +: 8] = new_v[8*b +: 8];
            end
        end
        return res;
    endfunction

    assign wr_c       = i_stb && i_wr_en;
    assign sel_c      = i_addr[4:2];
    assign tick_c     = (presc_q == PRESC_LAST);
    assign mtime_wr_c = wr_c && (|i_wr_mask) &&
                        ((sel_c == REG_MTIME_LO) || (sel_c == REG_MTIME_HI));

    // Prescaler free-runs 0..MTIME_PRESCALE-1, unaffected by bus writes.
    always_comb begin
        presc_d = presc_q + PW'(1);
        if (tick_c) begin
            presc_d = '0;
        end
    end

    // Register next-state: increment unless a mtime write lands, then apply byte writes.
    always_comb begin
        mtime_d    = mtime_q;
        mtimecmp_d = mtimecmp_q;
        msip_d     = msip_q;
        if (tick_c && !mtime_wr_c) begin
            mtime_d = mtime_q + TW'(1);
        end
        if (wr_c) begin
            case (sel_c)
                REG_MTIME_LO: mtime_d[31:0]     = merge_bytes(mtime_q[31:0], i_data, i_wr_mask);
                REG_MTIME_HI: mtime_d[63:32]    = merge_bytes(mtime_q[63:32], i_data, i_wr_mask);
                REG_CMP_LO:   mtimecmp_d[31:0]  = merge_bytes(mtimecmp_q[31:0], i_data, i_wr_mask);
                REG_CMP_HI:   mtimecmp_d[63:32] = merge_bytes(mtimecmp_q[63:32], i_data, i_wr_mask);
                REG_MSIP: begin
                    if (i_wr_mask[0]) begin
                        msip_d = i_data[0];
                    end
                end
                default: ;
            endcase
        end
    end

    // Read mux over the pre-access register values.
    always_comb begin
        rdata_c = '0;
        case (sel_c)
            REG_MTIME_LO: rdata_c = mtime_q[31:0];
            REG_MTIME_HI: rdata_c = mtime_q[63:32];
            REG_CMP_LO:   rdata_c = mtimecmp_q[31:0];
            REG_CMP_HI:   rdata_c = mtimecmp_q[63:32];
            REG_MSIP:     rdata_c = DW'(msip_q);
            default:      rdata_c = '0;
        endcase
    end

    // Timer, compare, msip and prescaler state.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            presc_q    <= '0;
            mtime_q    <= '0;
            mtimecmp_q <= '1;
            msip_q     <= 1'b0;
        end else begin
            presc_q    <= presc_d;
            mtime_q    <= mtime_d;
            mtimecmp_q <= mtimecmp_d;
            msip_q     <= msip_d;
        end
    end

    // Bus response: ack follows strobe by one cycle, read data held until the next strobe.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            ack_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            ack_q <= i_stb;
            if (i_stb) begin
                rdata_q <= rdata_c;
            end
        end
    end

    // Interrupt levels registered from current register state.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            timer_irq_q <= 1'b0;
            sw_irq_q    <= 1'b0;
        end else begin
            timer_irq_q <= (mtime_q >= mtimecmp_q);
            sw_irq_q    <= msip_q;
        end
    end

    assign o_ack                = ack_q;
    assign o_data               = rdata_q;
    assign o_timer_interrupt    = timer_irq_q;
    assign o_software_interrupt = sw_irq_q;

endmodule

// File: tb/tb_asrv32_vic.sv
// Directed self-checking bench for asrv32_vic (prescale 1 and prescale 4 instances).
module tb_asrv32_vic;

    logic        clk = 1'b0;
    logic        rst_n;

    logic [31:0] addr, wdata;
    logic [3:0]  mask;
    logic        wr_en, stb;
    logic        ack, timer_irq, sw_irq;
    logic [31:0] rdata;

    logic [31:0] addr4, wdata4;
    logic [3:0]  mask4;
    logic        wr_en4, stb4;
    logic        ack4, timer_irq4, sw_irq4;
    logic [31:0] rdata4;

    int checks = 0;
    int errors = 0;
    int cyc;

    logic [31:0] rd;
    logic        ak;

    always #5 clk = ~clk;

    // Posedges since the last reset release.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    asrv32_vic #(.BASE_ADDR(32'h8000_0000), .MTIME_PRESCALE(1)) u_dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_addr(addr), .i_data(wdata),
        .i_wr_mask(mask), .i_wr_en(wr_en), .i_stb(stb), .o_ack(ack),
        .o_data(rdata), .o_timer_interrupt(timer_irq), .o_software_interrupt(sw_irq)
    );

    asrv32_vic #(.BASE_ADDR(32'h8000_0000), .MTIME_PRESCALE(4)) u_dut4 (
        .i_clk(clk), .i_rst_n(rst_n), .i_addr(addr4), .i_data(wdata4),
        .i_wr_mask(mask4), .i_wr_en(wr_en4), .i_stb(stb4), .o_ack(ack4),
        .o_data(rdata4), .o_timer_interrupt(timer_irq4), .o_software_interrupt(sw_irq4)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One access on the prescale-1 instance, starting and ending on a negedge.
    task automatic bus1(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m,
                        input logic we, output logic [31:0] r, output logic k);
        addr = 32'h8000_0000 | a; wdata = d; mask = m; wr_en = we; stb = 1'b1;
        @(negedge clk);
        stb = 1'b0; wr_en = 1'b0;
        r = rdata; k = ack;
    endtask

    task automatic bus4(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m,
                        input logic we, output logic [31:0] r, output logic k);
        addr4 = 32'h8000_0000 | a; wdata4 = d; mask4 = m; wr_en4 = we; stb4 = 1'b1;
        @(negedge clk);
        stb4 = 1'b0; wr_en4 = 1'b0;
        r = rdata4; k = ack4;
    endtask

    task automatic rd1(input string tag, input logic [31:0] a, input logic [31:0] exp);
        logic [31:0] r;
        logic        k;
        bus1(a, 32'h0, 4'h0, 1'b0, r, k);
        check({tag, "_ack"}, 64'(k), 64'd1);
        check(tag, 64'(r), 64'(exp));
    endtask

    task automatic wr1(input string tag, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] m);
        logic [31:0] r;
        logic        k;
        bus1(a, d, m, 1'b1, r, k);
        check({tag, "_ack"}, 64'(k), 64'd1);
    endtask

    initial begin
        rst_n = 1'b0;
        addr = '0; wdata = '0; mask = '0; wr_en = 1'b0; stb = 1'b0;
        addr4 = '0; wdata4 = '0; mask4 = '0; wr_en4 = 1'b0; stb4 = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_ack", 64'(ack), 64'd0);
        check("rst_data", 64'(rdata), 64'd0);
        check("rst_tirq", 64'(timer_irq), 64'd0);
        check("rst_sirq", 64'(sw_irq), 64'd0);

        // Reset release and free-running count.
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        rd1("mtime_after10", 32'h00, 32'd10);
        check("idle_ack", 64'(ack), 64'd1);
        @(negedge clk);
        check("ack_single", 64'(ack), 64'd0);
        rd1("cmp_lo_rst", 32'h08, 32'hFFFF_FFFF);
        rd1("cmp_hi_rst", 32'h0C, 32'hFFFF_FFFF);
        check("tirq_rst_cmp", 64'(timer_irq), 64'd0);

        // Compare fire: mtime restarts at 0, compare at 20.
        wr1("w_mtime_lo0", 32'h00, 32'd0, 4'hF);
        wr1("w_cmp_hi0", 32'h0C, 32'd0, 4'hF);
        wr1("w_cmp_lo20", 32'h08, 32'd20, 4'hF);
        repeat (18) @(negedge clk);
        check("tirq_at_mtime20", 64'(timer_irq), 64'd0);
        @(negedge clk);
        check("tirq_rise", 64'(timer_irq), 64'd1);
        repeat (5) @(negedge clk);
        check("tirq_hold", 64'(timer_irq), 64'd1);
        wr1("w_cmp_lo1000", 32'h08, 32'd1000, 4'hF);
        check("tirq_lag", 64'(timer_irq), 64'd1);
        @(negedge clk);
        check("tirq_clear", 64'(timer_irq), 64'd0);

        // Wrap through all-ones with compare at 5.
        wr1("w_cmp_lo5", 32'h08, 32'd5, 4'hF);
        wr1("w_mtime_hi", 32'h04, 32'hFFFF_FFFF, 4'hF);
        wr1("w_mtime_lo", 32'h00, 32'hFFFF_FFFE, 4'hF);
        repeat (2) @(negedge clk);
        check("tirq_pre_wrap", 64'(timer_irq), 64'd1);
        rd1("mtime_lo_wrap", 32'h00, 32'd0);
        check("tirq_post_wrap", 64'(timer_irq), 64'd0);
        rd1("mtime_hi_wrap", 32'h04, 32'd0);
        repeat (3) @(negedge clk);
        check("tirq_at4", 64'(timer_irq), 64'd0);
        @(negedge clk);
        check("tirq_at5", 64'(timer_irq), 64'd1);

        // Byte-masked writes.
        wr1("w_cmp_ones", 32'h08, 32'hFFFF_FFFF, 4'hF);
        bus1(32'h08, 32'h1234_5678, 4'b0101, 1'b1, rd, ak);
        check("mask_wr_ack", 64'(ak), 64'd1);
        check("mask_wr_prevalue", 64'(rd), 64'hFFFF_FFFF);
        rd1("mask_readback", 32'h08, 32'hFF34_FF78);
        wr1("w_mask0", 32'h08, 32'h0000_0000, 4'h0);
        rd1("mask0_readback", 32'h08, 32'hFF34_FF78);

        // Software interrupt.
        wr1("w_msip1", 32'h10, 32'h0000_0001, 4'h1);
        check("sirq_edge1", 64'(sw_irq), 64'd0);
        @(negedge clk);
        check("sirq_edge2", 64'(sw_irq), 64'd1);
        rd1("msip_read1", 32'h10, 32'd1);
        wr1("w_msip0", 32'h10, 32'hFFFF_FFFE, 4'hF);
        check("sirq_lag", 64'(sw_irq), 64'd1);
        @(negedge clk);
        check("sirq_clear", 64'(sw_irq), 64'd0);

        // Unmapped offset.
        bus1(32'h18, 32'hFFFF_FFFF, 4'hF, 1'b1, rd, ak);
        check("unmapped_wr_ack", 64'(ak), 64'd1);
        check("unmapped_wr_data", 64'(rd), 64'd0);
        rd1("unmapped_read", 32'h18, 32'd0);
        rd1("cmp_after_unmapped", 32'h08, 32'hFF34_FF78);
        rd1("msip_after_unmapped", 32'h10, 32'd0);

        // Prescale 4: write mtime_lo in a terminal cycle.
        for (int i = 0; i < 4 && (cyc % 4) != 3; i++) @(negedge clk);
        bus4(32'h00, 32'd100, 4'hF, 1'b1, rd, ak);
        check("p4_wr_ack", 64'(ak), 64'd1);
        bus4(32'h00, 32'd0, 4'h0, 1'b0, rd, ak);
        check("p4_collision", 64'(rd), 64'd100);
        repeat (3) @(negedge clk);
        bus4(32'h00, 32'd0, 4'h0, 1'b0, rd, ak);
        check("p4_next_tick", 64'(rd), 64'd101);

        // Reset in the middle of a strobe.
        wr1("w_cmp_lo0", 32'h08, 32'd0, 4'hF);
        wr1("w_msip_set", 32'h10, 32'd1, 4'h1);
        repeat (2) @(negedge clk);
        check("pre_rst_tirq", 64'(timer_irq), 64'd1);
        check("pre_rst_sirq", 64'(sw_irq), 64'd1);
        rd1("pre_rst_msip", 32'h10, 32'd1);
        addr = 32'h8000_000C; wdata = 32'h0000_1234; mask = 4'hF; wr_en = 1'b1; stb = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_now_ack", 64'(ack), 64'd0);
        check("rst_now_data", 64'(rdata), 64'd0);
        check("rst_now_tirq", 64'(timer_irq), 64'd0);
        check("rst_now_sirq", 64'(sw_irq), 64'd0);
        @(negedge clk);
        check("rst_hold_ack", 64'(ack), 64'd0);
        stb = 1'b0; wr_en = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_ack", 64'(ack), 64'd0);
        rd1("post_rst_cmp_hi", 32'h0C, 32'hFFFF_FFFF);
        rd1("post_rst_msip", 32'h10, 32'd0);
        check("post_rst_tirq", 64'(timer_irq), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
